// File: rtl/mux_pkg.sv
// mux_pkg: shared constants and helpers for the round-robin stream mux.
//   MODE_SEL / MODE_RR : values of the mode input.
//   clog2_min1(n)      : index width for n entries, never less than 1.
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority picker.
//   req       in   N      request vector.
//   ptr       in   SELW   last granted index; scanning starts at ptr+1, ptr is last.
//   gnt_valid out  1      some request was found.
//   gnt_idx   out  SELW   index of the winner (0 when none).
//   gnt       out  N      one-hot winner (all 0 when none).
module rr_pick
    import mux_pkg::*;
#(
    parameter int N = 4,
    localparam int SELW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx,
    output logic [N-1:0]    gnt
);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        gnt       = '0;
        // offset 1..N covers every channel once, with ptr itself visited last
        for (int k = 1; k <= N; k++) begin
            if (!gnt_valid && req[(int'(ptr) + k) % N]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SELW'((int'(ptr) + k) % N);
            end
        end
        if (gnt_valid) gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel, W-bit registered stream mux with valid/ready.
//   clk, reset_n          clock, async active-low reset.
//   in_data  [N*W]        channel i at in_data[i*W +: W].
//   in_valid [N]          per-channel valid.
//   in_ready [N]          per-channel accept, at most one bit set.
//   mode                  MODE_SEL (use sel) or MODE_RR (round-robin).
//   sel      [SELW]       channel index for MODE_SEL.
//   out_data/out_src      registered word and the channel it came from.
//   out_valid/out_ready   output handshake.
module rr_stream_mux
    import mux_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 4,
    localparam int SELW = clog2_min1(N)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_src,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [N-1:0][W-1:0] ch_data;
    logic [SELW-1:0]     ptr;
    logic                ld;

    logic                rr_valid;
    logic [SELW-1:0]     rr_idx;
    logic [N-1:0]        rr_gnt;

    logic                sel_valid;
    logic [N-1:0]        sel_gnt;

    logic                grant_valid;
    logic [SELW-1:0]     grant_idx;
    logic [N-1:0]        grant_oh;

    assign ch_data = in_data;

    // register may load when empty or when the consumer drains it this cycle
    assign ld = !out_valid || out_ready;

    rr_pick #(.N(N)) u_pick (
        .req       (in_valid),
        .ptr       (ptr),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx),
        .gnt       (rr_gnt)
    );

    // explicit select; an index past the last channel never grants
    always_comb begin
        sel_valid = 1'b0;
        sel_gnt   = '0;
        if (int'(sel) < N) begin
            sel_valid = in_valid[sel];
            if (sel_valid) sel_gnt[sel] = 1'b1;
        end
    end

    always_comb begin
        if (mode == MODE_RR) begin
            grant_valid = rr_valid;
            grant_idx   = rr_idx;
            grant_oh    = rr_gnt;
        end else begin
            grant_valid = sel_valid;
            grant_idx   = sel;
            grant_oh    = sel_gnt;
        end
    end

    // gated by reset_n so no producer sees an accept while reset is held
    assign in_ready = (reset_n && ld && grant_valid) ? grant_oh : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= SELW'(N - 1);   // first RR grant after reset lands on 0
        end else if (ld) begin
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[grant_idx];
                out_src   <= grant_idx;
                ptr       <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
module tb_rr_stream_mux;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [1:0]     sel;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_valid;
    logic           out_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_stream_mux #(.W(W), .N(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic       rst_n;
        logic       mode;
        logic [1:0] sel;
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] e_rdy;   // in_ready before the edge
        logic       e_ov;    // after the edge
        logic [7:0] e_d;
        logic [1:0] e_src;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic m, input logic [1:0] s, input logic [3:0] iv,
                       input logic o, input logic [3:0] er, input logic eov,
                       input logic [7:0] ed, input logic [1:0] es);
        vec_t v;
        v.rst_n = r; v.mode = m; v.sel = s; v.iv = iv; v.ordy = o;
        v.e_rdy = er; v.e_ov = eov; v.e_d = ed; v.e_src = es;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    initial begin
        // SEL sweep / SEL invalid
        add(1, 0, 2, 4'b1111, 1, 4'b0100, 1, 8'hA2, 2);
        add(1, 0, 1, 4'b1101, 1, 4'b0000, 0, 8'hA2, 2);
        add(1, 0, 1, 4'b1111, 1, 4'b0010, 1, 8'hA1, 1);
        // reset, then RR fairness from channel 0
        add(0, 1, 0, 4'b1111, 1, 4'b0000, 0, 8'h00, 0);
        for (int i = 0; i < 8; i++)
            add(1, 1, 0, 4'b1111, 1, 4'(1 << (i % 4)), 1, 8'(8'hA0 + i % 4), 2'(i % 4));
        // park ptr at 2 via SEL (ptr follows SEL grants), then RR skip/wrap
        add(1, 0, 2, 4'b0100, 1, 4'b0100, 1, 8'hA2, 2);
        add(1, 1, 0, 4'b0011, 1, 4'b0001, 1, 8'hA0, 0);
        add(1, 1, 0, 4'b0011, 1, 4'b0010, 1, 8'hA1, 1);
        add(1, 1, 0, 4'b0011, 1, 4'b0001, 1, 8'hA0, 0);
        // backpressure for 3 cycles, then pop+push together
        for (int i = 0; i < 3; i++)
            add(1, 1, 0, 4'b0011, 0, 4'b0000, 1, 8'hA0, 0);
        add(1, 1, 0, 4'b0011, 1, 4'b0010, 1, 8'hA1, 1);
        // no requests: valid drops, data/src hold
        add(1, 1, 0, 4'b0000, 1, 4'b0000, 0, 8'hA1, 1);
        add(1, 1, 0, 4'b0000, 0, 4'b0000, 0, 8'hA1, 1);
        // empty register loads even with out_ready=0
        add(1, 0, 3, 4'b1000, 0, 4'b1000, 1, 8'hA3, 3);
        // mode change while a word is held does not disturb it
        add(1, 1, 0, 4'b1111, 0, 4'b0000, 1, 8'hA3, 3);
        add(1, 1, 0, 4'b1111, 1, 4'b0001, 1, 8'hA0, 0);

        // reset asserted with valid inputs: everything quiet, no clock needed
        reset_n = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
        set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data",  32'(out_data),  32'd0);
        chk("reset_out_src",   32'(out_src),   32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            reset_n   = vecs[i].rst_n;
            mode      = vecs[i].mode;
            sel       = vecs[i].sel;
            in_valid  = vecs[i].iv;
            out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d_out_data", i),  32'(out_data),  32'(vecs[i].e_d));
            chk($sformatf("v%0d_out_src", i),   32'(out_src),   32'(vecs[i].e_src));
        end

        // datapath bits: distinct patterns per channel through SEL
        @(negedge clk);
        reset_n = 1'b1; mode = 1'b0; out_ready = 1'b1; in_valid = 4'b1111;
        set_data(8'hFF, 8'h00, 8'h5A, 8'hC3);
        sel = 2'd3;
        @(posedge clk); #1;
        chk("pat_c3_data", 32'(out_data), 32'hC3);
        @(negedge clk); sel = 2'd0;
        @(posedge clk); #1;
        chk("pat_ff_data", 32'(out_data), 32'hFF);
        chk("pat_ff_src",  32'(out_src),  32'd0);

        // reset mid-stream with a word held: dropped immediately
        @(negedge clk);
        mode = 1'b1; set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3); out_ready = 1'b0;
        @(posedge clk); #1;
        chk("mid_held_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid",    32'(out_valid), 32'd0);
        chk("mid_rst_data",     32'(out_data),  32'd0);
        chk("mid_rst_in_ready", 32'(in_ready),  32'd0);
        @(negedge clk);
        reset_n = 1'b1; out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'b0001);
        @(posedge clk); #1;
        chk("post_rst_src",  32'(out_src),  32'd0);
        chk("post_rst_data", 32'(out_data), 32'hA0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
